// File: rtl/seqdec_pkg.sv
// Shared defaults and sizing helper for the programmable serial sequence detector.
package seqdec_pkg;

  localparam int unsigned PAT_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 16;

  // The fill counter must be able to hold the value PAT_W itself.
  function automatic int unsigned fill_w(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seqdec_win.sv
// Sliding bit window: shift history, saturating fill count and fresh-sample flag.
module seqdec_win
  import seqdec_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             bit_i,
  input  logic             flush_i,
  input  logic             restart_i,
  output logic [PAT_W-1:0] hist_o,
  output logic             new_o,
  output logic             full_o
);

  localparam int unsigned      FW       = fill_w(PAT_W);
  localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_W);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             new_q,  new_d;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    new_d  = valid_i;
    if (valid_i) begin
      hist_d = {hist_q[PAT_W-2:0], bit_i};
      if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
    end
    // Non-overlapping restart: the bit sampled on the hit edge seeds the new window.
    if (restart_i) fill_d = valid_i ? FW'(1) : '0;
    if (flush_i) begin
      hist_d = '0;
      fill_d = '0;
      new_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= '0;
      fill_q <= '0;
      new_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      new_q  <= new_d;
    end
  end

  assign hist_o = hist_q;
  assign new_o  = new_q;
  assign full_o = (fill_q == FILL_MAX);

endmodule

// File: rtl/seqdec_prog.sv
// Programmable masked sequence detector with saturating match counter and hit pulse.
module seqdec_prog
  import seqdec_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InA,
  input  logic             Valid,
  input  logic             Load,
  input  logic [PAT_W-1:0] PatIn,
  input  logic [PAT_W-1:0] MaskIn,
  input  logic             Overlap,
  input  logic             Clear,
  output logic [CNT_W-1:0] Out,
  output logic             Hit,
  output logic             Sat
);

  logic [PAT_W-1:0] pat_q,  pat_d;
  logic [PAT_W-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic             hit_q,  hit_d;
  logic             sat_q,  sat_d;

  logic [PAT_W-1:0] hist;
  logic             win_new;
  logic             win_full;
  logic             flush;
  logic             match;
  logic             take;

  assign flush = Load | Clear;
  assign match = win_new & win_full & (((hist ^ pat_q) & mask_q) == '0);
  // A match pending on a Load/Clear edge is dropped.
  assign take  = match & ~flush;

  seqdec_win #(.PAT_W(PAT_W)) u_win (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .valid_i   (Valid),
    .bit_i     (InA),
    .flush_i   (flush),
    .restart_i (take & ~Overlap),
    .hist_o    (hist),
    .new_o     (win_new),
    .full_o    (win_full)
  );

  always_comb begin
    pat_d  = pat_q;
    mask_d = mask_q;
    cnt_d  = cnt_q;
    sat_d  = sat_q;
    hit_d  = take;
    if (take) begin
      if (&cnt_q) sat_d = 1'b1;
      else        cnt_d = cnt_q + 1'b1;
    end
    if (Load) begin
      pat_d  = PatIn;
      mask_d = MaskIn;
    end
    if (Clear) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pat_q  <= '0;
      mask_q <= '0;
      cnt_q  <= '0;
      hit_q  <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      hit_q  <= hit_d;
      sat_q  <= sat_d;
    end
  end

  assign Out = cnt_q;
  assign Hit = hit_q;
  assign Sat = sat_q;

endmodule

// File: tb/tb_seqdec_prog.sv
// Scoreboard bench: DUT 0 is PAT_W=8/CNT_W=3, DUT 1 is PAT_W=4/CNT_W=4.
module tb_seqdec_prog;

  typedef struct {
    int cyc;
    int out;
    bit sat;
  } exp_t;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;

  logic       rst8, v8, a8, ld8, cl8, ov8;
  logic [7:0] pat8, msk8;
  logic [2:0] out8;
  logic       hit8, sat8;

  logic       rst4, v4, a4, ld4, cl4, ov4;
  logic [3:0] pat4, msk4;
  logic [3:0] out4;
  logic       hit4, sat4;

  exp_t q [2][$];
  int   e_cnt [2];
  bit   e_sat [2];
  int   e_max [2];

  seqdec_prog #(.PAT_W(8), .CNT_W(3)) u_p8 (
    .Clk(clk), .Reset(rst8), .InA(a8), .Valid(v8), .Load(ld8),
    .PatIn(pat8), .MaskIn(msk8), .Overlap(ov8), .Clear(cl8),
    .Out(out8), .Hit(hit8), .Sat(sat8)
  );

  seqdec_prog #(.PAT_W(4), .CNT_W(4)) u_p4 (
    .Clk(clk), .Reset(rst4), .InA(a4), .Valid(v4), .Load(ld4),
    .PatIn(pat4), .MaskIn(msk4), .Overlap(ov4), .Clear(cl4),
    .Out(out4), .Hit(hit4), .Sat(sat4)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic mon(input int s, input logic h, input int o, input logic st);
    exp_t e;
    if (q[s].size() > 0 && q[s][0].cyc < cyc) begin
      e = q[s].pop_front();
      n_vec++;
      n_err++;
      $display("FAIL hit_missing dut%0d: no Hit at cycle %0d, required Hit with Out=%0d", s, e.cyc, e.out);
    end
    if (h === 1'b1) begin
      n_vec++;
      if (q[s].size() == 0) begin
        n_err++;
        $display("FAIL hit_unexpected dut%0d: Hit at cycle %0d Out=%0d, required no Hit", s, cyc, o);
      end else begin
        e = q[s].pop_front();
        if (e.cyc != cyc || e.out != o || e.sat != st) begin
          n_err++;
          $display("FAIL hit dut%0d: got cyc=%0d Out=%0d Sat=%0b, required cyc=%0d Out=%0d Sat=%0b",
                   s, cyc, o, st, e.cyc, e.out, e.sat);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, hit8, int'(out8), sat8);
    mon(1, hit4, int'(out4), sat4);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic drv(input int s, input logic v, input logic a, input logic ld,
                     input logic cl, input logic rs);
    @(negedge clk);
    {v8, a8, ld8, cl8, rst8} = '0;
    {v4, a4, ld4, cl4, rst4} = '0;
    if (s == 0) {v8, a8, ld8, cl8, rst8} = {v, a, ld, cl, rs};
    else        {v4, a4, ld4, cl4, rst4} = {v, a, ld, cl, rs};
  endtask

  task automatic idle(input int n);
    repeat (n) drv(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Called right after the final bit of a match is driven: Hit follows the next edge.
  task automatic expect_hit(input int s);
    exp_t e;
    if (e_cnt[s] == e_max[s]) e_sat[s] = 1'b1;
    else                      e_cnt[s]++;
    e.cyc = cyc + 2;
    e.out = e_cnt[s];
    e.sat = e_sat[s];
    q[s].push_back(e);
  endtask

  task automatic clear_model(input int s);
    e_cnt[s] = 0;
    e_sat[s] = 1'b0;
  endtask

  // Load and Clear together: new pattern, zero count.
  task automatic cfg(input int s, input logic [7:0] p, input logic [7:0] m, input logic ov);
    if (s == 0) begin pat8 = p; msk8 = m; ov8 = ov; end
    else begin pat4 = p[3:0]; msk4 = m[3:0]; ov4 = ov; end
    drv(s, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    clear_model(s);
  endtask

  // data is sent MSB first; hits[i] marks the i-th sent bit as completing a match.
  task automatic send(input int s, input logic [31:0] data, input int n, input int gap,
                      input logic [31:0] hits);
    for (int i = 0; i < n; i++) begin
      drv(s, 1'b1, data[n-1-i], 1'b0, 1'b0, 1'b0);
      if (hits[i]) expect_hit(s);
      repeat (gap) drv(s, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    e_max[0] = 7;
    e_max[1] = 15;
    clear_model(0);
    clear_model(1);
    {v8, a8, ld8, cl8, ov8, pat8, msk8} = '0;
    {v4, a4, ld4, cl4, ov4, pat4, msk4} = '0;
    rst8 = 1'b1;
    rst4 = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_out8", int'(out8), 0);
    chk("reset_hit8", int'(hit8), 0);
    chk("reset_sat8", int'(sat8), 0);
    chk("reset_out4", int'(out4), 0);
    chk("reset_hit4", int'(hit4), 0);
    chk("reset_sat4", int'(sat4), 0);

    // 0x85 at bits 0-7 and 24-31; the 0x42/0x85 seam holds a third, overlapping one ending at bit 24.
    cfg(0, 8'h85, 8'hFF, 1'b1);
    send(0, 32'h8597_4285, 32, 0, 32'h8100_0080);
    idle(4);
    chk("p85_ovl_out", int'(out8), 3);
    cfg(0, 8'h85, 8'hFF, 1'b0);
    send(0, 32'h8597_4285, 32, 0, 32'h0100_0080);
    idle(4);
    chk("p85_novl_out", int'(out8), 2);

    cfg(1, 8'h0A, 8'h0F, 1'b1);
    send(1, 32'hAA, 8, 0, 32'hA8);
    idle(4);
    chk("p1010_ovl_out", int'(out4), 3);
    cfg(1, 8'h0A, 8'h0F, 1'b0);
    send(1, 32'hAA, 8, 0, 32'h88);
    idle(4);
    chk("p1010_novl_out", int'(out4), 2);

    cfg(1, 8'h0A, 8'h0F, 1'b1);
    send(1, 32'hAA, 8, 3, 32'hA8);
    idle(4);
    chk("gap_ovl_out", int'(out4), 3);
    cfg(1, 8'h0A, 8'h0F, 1'b0);
    send(1, 32'hAA, 8, 3, 32'h88);
    idle(4);
    chk("gap_novl_out", int'(out4), 2);

    cfg(0, 8'h00, 8'h00, 1'b1);
    send(0, 32'h1234, 16, 0, 32'hFF80);
    idle(4);
    chk("sat_out", int'(out8), 7);
    chk("sat_flag", int'(sat8), 1);
    drv(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    clear_model(0);
    idle(2);
    chk("sat_clr_out", int'(out8), 0);
    chk("sat_clr_flag", int'(sat8), 0);

    cfg(0, 8'hF5, 8'h0F, 1'b1);
    send(0, 32'h35, 8, 0, 32'h80);
    send(0, 32'h35, 8, 0, 32'h00);
    drv(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("load_drop_out", int'(out8), 1);
    send(0, 32'h35, 8, 0, 32'h00);
    drv(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    clear_model(0);
    idle(4);
    chk("clear_drop_out", int'(out8), 0);

    cfg(0, 8'hF5, 8'h0F, 1'b1);
    send(0, 32'h35, 8, 0, 32'h80);
    send(0, 32'h3, 4, 0, 32'h0);
    drv(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    clear_model(0);
    idle(1);
    chk("midrst_out", int'(out8), 0);
    chk("midrst_hit", int'(hit8), 0);
    chk("midrst_sat", int'(sat8), 0);
    drv(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(0, 32'h535, 12, 0, 32'h800);
    idle(4);
    chk("midrst_relock_out", int'(out8), 1);

    idle(4);
    chk("drain_dut0", q[0].size(), 0);
    chk("drain_dut1", q[1].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
